// File: rtl/icache_l1_pkg.sv
// Shared constants and FSM encoding for the direct-mapped L1 instruction cache.
// Derived widths follow the default geometry; the top re-derives them from its parameters.
package icache_l1_pkg;

   localparam int WORD_W           = 32;
   localparam int BLOCK_WORDS      = 4;
   localparam int NUM_LINES        = 32;
   localparam int ADDR_W           = 32;
   localparam int MEM_BLOCK_ADDR_W = 10;

   localparam int OFF_W  = $clog2(BLOCK_WORDS);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int LINE_W = BLOCK_WORDS * WORD_W;

   typedef enum logic [1:0] {
      ICACHE_IDLE  = 2'd0,
      ICACHE_FETCH = 2'd1,
      ICACHE_GAP   = 2'd2
   } icache_state_t;

endpackage

// File: rtl/icache_l1_array.sv
// Valid/tag/data storage: combinational read, single write port, flush.
// Only the valid bits are reset; tag and data contents are don't-care until filled.
module icache_l1_array
   import icache_l1_pkg::*;
#(
   parameter int P_LINES = NUM_LINES,
   parameter int P_IDX_W = IDX_W,
   parameter int P_TAG_W = TAG_W,
   parameter int P_LINE_W = LINE_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_flush,
   input  logic [P_IDX_W-1:0]  i_rd_idx,
   output logic                o_rd_valid,
   output logic [P_TAG_W-1:0]  o_rd_tag,
   output logic [P_LINE_W-1:0] o_rd_line,
   input  logic                i_we,
   input  logic [P_IDX_W-1:0]  i_wr_idx,
   input  logic [P_TAG_W-1:0]  i_wr_tag,
   input  logic [P_LINE_W-1:0] i_wr_line
);

   logic [P_LINES-1:0]  r_valid;
   logic [P_TAG_W-1:0]  r_tag  [P_LINES];
   logic [P_LINE_W-1:0] r_data [P_LINES];

   // Flush beats a simultaneous fill: the line data lands but stays invalid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (i_flush) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (i_we) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_line;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_l1.sv
// Direct-mapped read-only L1 I-cache: zero-latency hits, block refill on miss.
// A one-cycle GAP after each fill drops mem_ren so every request sees full latency.
module icache_l1
   import icache_l1_pkg::*;
#(
   parameter int WORD_W           = icache_l1_pkg::WORD_W,
   parameter int BLOCK_WORDS      = icache_l1_pkg::BLOCK_WORDS,
   parameter int NUM_LINES        = icache_l1_pkg::NUM_LINES,
   parameter int ADDR_W           = icache_l1_pkg::ADDR_W,
   parameter int MEM_BLOCK_ADDR_W = icache_l1_pkg::MEM_BLOCK_ADDR_W
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cpu_ren,
   input  logic [ADDR_W-1:0]             cpu_addr,
   input  logic                          flush,
   output logic                          cpu_ready,
   output logic [WORD_W-1:0]             cpu_rdata,
   output logic                          mem_ren,
   output logic [MEM_BLOCK_ADDR_W-1:0]   mem_block_address,
   input  logic                          mem_ready,
   input  logic [BLOCK_WORDS*WORD_W-1:0] mem_dout
);

   localparam int L_OFF_W  = $clog2(BLOCK_WORDS);
   localparam int L_IDX_W  = $clog2(NUM_LINES);
   localparam int L_SHIFT  = 2 + L_OFF_W;
   localparam int L_TAG_W  = ADDR_W - L_SHIFT - L_IDX_W;
   localparam int L_LINE_W = BLOCK_WORDS * WORD_W;

   icache_state_t r_state;
   logic [L_IDX_W-1:0] r_idx;
   logic [L_TAG_W-1:0] r_tag;

   logic [L_OFF_W-1:0]          w_off;
   logic [L_IDX_W-1:0]          w_idx;
   logic [L_TAG_W-1:0]          w_tag;
   logic [MEM_BLOCK_ADDR_W-1:0] w_blk;
   logic                        w_valid;
   logic [L_TAG_W-1:0]          w_rd_tag;
   logic [L_LINE_W-1:0]         w_line;
   logic                        w_hit;
   logic                        w_we;
   logic                        w_unused;

   assign w_off = cpu_addr[2 +: L_OFF_W];
   assign w_idx = cpu_addr[L_SHIFT +: L_IDX_W];
   assign w_tag = cpu_addr[ADDR_W-1 -: L_TAG_W];
   assign w_blk = cpu_addr[L_SHIFT +: MEM_BLOCK_ADDR_W];
   assign w_unused = ^cpu_addr[1:0];

   assign w_hit = (r_state == ICACHE_IDLE) & cpu_ren
                & w_valid & (w_rd_tag == w_tag);
   assign w_we  = (r_state == ICACHE_FETCH) & mem_ready;

   assign cpu_ready = w_hit;
   assign cpu_rdata = w_hit ? w_line[w_off*WORD_W +: WORD_W]
                            : '0;

   icache_l1_array #(
      .P_LINES  (NUM_LINES),
      .P_IDX_W  (L_IDX_W),
      .P_TAG_W  (L_TAG_W),
      .P_LINE_W (L_LINE_W)
   ) u_array (
      .clock      (clock),
      .reset      (reset),
      .i_flush    (flush),
      .i_rd_idx   (w_idx),
      .o_rd_valid (w_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_line  (w_line),
      .i_we       (w_we),
      .i_wr_idx   (r_idx),
      .i_wr_tag   (r_tag),
      .i_wr_line  (mem_dout)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state           <= ICACHE_IDLE;
         r_idx             <= '0;
         r_tag             <= '0;
         mem_ren           <= 1'b0;
         mem_block_address <= '0;
      end else begin
         unique case (r_state)
            ICACHE_IDLE: begin
               if (cpu_ren && !w_hit) begin
                  r_idx             <= w_idx;
                  r_tag             <= w_tag;
                  mem_block_address <= w_blk;
                  mem_ren           <= 1'b1;
                  r_state           <= ICACHE_FETCH;
               end
            end
            ICACHE_FETCH: begin
               if (mem_ready) begin
                  mem_ren <= 1'b0;
                  r_state <= ICACHE_GAP;
               end
            end
            ICACHE_GAP: begin
               r_state <= ICACHE_IDLE;
            end
            default: begin
               mem_ren <= 1'b0;
               r_state <= ICACHE_IDLE;
            end
         endcase
      end
   end

endmodule
